fetch_unit: RTL

- Parametrised successor to the pipeline's IF stage.
- Generates the PC sequence, issues in-order requests to the instruction memory over a valid/ready handshake with arbitrary response latency (≥1 cycle), and buffers returned instructions in a FIFO_DEPTH-entry queue.
- Presents each instruction with its PC to decode over a valid/ready handshake.
- On branch or exception redirect, flushes the queue and discards all in-flight responses.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, in-order memory requests with credit
// limiting, a small instruction queue toward decode, and redirect flushing.
module fetch_unit #(
  parameter int unsigned          ADDR_W     = 32,
  parameter int unsigned          DATA_W     = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
  parameter logic [ADDR_W-1:0]    EXC_VEC    = ADDR_W'(32'h0000_0080),
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              except,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  // Handshakes: a transfer happens on a posedge where valid && ready are both high.
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  count_q, count_d, inflight_q, inflight_d, discard_q, discard_d;
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d, tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
  logic [DATA_W-1:0] inst_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] tag_mem  [FIFO_DEPTH];

  logic           redirect, rsp_live, rsp_keep, rsp_drop, deq, acc;
  logic [CNT_W:0] occ, credit;

  assign redirect = br || except;
  // Responses with nothing outstanding are leftovers from before a reset.
  assign rsp_live = imem_rsp_valid && ((inflight_q | discard_q) != '0);
  assign rsp_drop = rsp_live && (discard_q != '0);
  assign rsp_keep = rsp_live && (discard_q == '0) && !redirect;

  assign if_valid = !rst && (count_q != '0);
  assign if_pc    = pc_mem[rd_q];
  assign if_inst  = inst_mem[rd_q];
  assign deq      = if_valid && if_ready;

  assign occ    = {1'b0, count_q} + {1'b0, inflight_q} - {{CNT_W{1'b0}}, deq};
  assign credit = {1'b0, discard_q} + {1'b0, inflight_q};

  assign imem_req_addr  = pc_q;
  assign imem_req_valid = !rst && !redirect && (occ < DEPTH_C) && (credit < DEPTH_C);
  assign acc            = imem_req_valid && imem_req_ready;

  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    if (redirect) begin
      pc_d       = except ? EXC_VEC : {br_target[ADDR_W-1:2], 2'b00};
      count_d    = '0;
      inflight_d = '0;
      discard_d  = discard_q + inflight_q - CNT_W'(rsp_live);
      rd_d       = '0;
      wr_d       = '0;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
    end else begin
      if (acc) pc_d = pc_q + ADDR_W'(4);
      inflight_d = inflight_q + CNT_W'(acc) - CNT_W'(rsp_keep);
      discard_d  = discard_q - CNT_W'(rsp_drop);
      count_d    = count_q + CNT_W'(rsp_keep) - CNT_W'(deq);
      rd_d       = rd_q + PTR_W'(deq);
      wr_d       = wr_q + PTR_W'(rsp_keep);
      tag_rd_d   = tag_rd_q + PTR_W'(rsp_keep);
      tag_wr_d   = tag_wr_q + PTR_W'(acc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // Issued PCs wait in tag_mem until their response pairs them with the data.
  always_ff @(posedge clk) begin
    if (acc) tag_mem[tag_wr_q] <= pc_q;
    if (rsp_keep) begin
      pc_mem[wr_q]   <= tag_mem[tag_rd_q];
      inst_mem[wr_q] <= imem_rsp_data;
    end
  end

endmodule
